multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Sequencing controller for the multi-cycle variant of the 32-bit MIPS core. Instruction and data accesses share one memory port, and one ALU is reused across cycles.
- Drives every datapath select and strobe from a state machine: PC, IR, register file, ALU operand muxes, memory and PC source.
- Supports wait-stated memory through a ready handshake, counts retired instructions, and traps on undefined opcodes.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- Opcode  input  6  inst[31:26] from the instruction register.
- mem_ready  input  1  memory has completed the current read or write this cycle.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load qualified by ALU Zero (beq).
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut register.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  instruction register load.
- MemtoReg  output  1  register write data select: 0 = ALUOut, 1 = MDR.
- RegDst  output  1  write register select: 0 = rt, 1 = rd.
- RegWrite  output  1  register file write.
- ALUSrcA  output  1  ALU A select: 0 = PC, 1 = register A.
- ALUSrcB  output  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- ALUOp  output  2  00 = add, 01 = sub, 10 = funct-decoded.
- PCSource  output  2  00 = ALU result, 01 = ALUOut register, 10 = jump target.
- retired  output  CNT_W  retired-instruction count.
- trap  output  1  sticky: undefined opcode decoded.
- state_o  output  4  current state, for debug.

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Reset values: state = FETCH, retired = 0, trap = 0. While reset is high, every strobe and select output is 0.
- Outputs are Moore decodes of the state. The only exceptions are IRWrite and PCWrite in FETCH, which are additionally gated by mem_ready.
- Opcodes decoded: R-type 0x00, lw 0x23, sw 0x2B, beq 0x04, j 0x02, addi 0x08. Any other opcode is undefined.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - Stays in FETCH while mem_ready=0.
  - When mem_ready=1: IRWrite=1 and PCWrite=1 (PC+4), then go to DECODE.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - Next state by opcode: lw/sw -> MEM_ADDR, R-type -> EXEC, beq -> BRANCH, j -> JUMP, addi -> ADDI_EXEC, undefined -> TRAP.
- MEM_ADDR:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next state: lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ:
  - Outputs: MemRead=1, IorD=1.
  - Holds until mem_ready=1, then -> MEM_WB.
- MEM_WB:
  - Outputs: RegWrite=1, MemtoReg=1, RegDst=0.
  - Next state: FETCH.
- MEM_WRITE:
  - Outputs: MemWrite=1, IorD=1.
  - Holds until mem_ready=1, then -> FETCH.
- EXEC:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - Next state: R_WB.
- R_WB:
  - Outputs: RegWrite=1, RegDst=1, MemtoReg=0.
  - Next state: FETCH.
- BRANCH:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
  - Next state: FETCH.
- JUMP:
  - Outputs: PCWrite=1, PCSource=10.
  - Next state: FETCH.
- ADDI_EXEC:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next state: ADDI_WB.
- ADDI_WB:
  - Outputs: RegWrite=1, RegDst=0, MemtoReg=0.
  - Next state: FETCH.
- TRAP:
  - Terminal until reset. All strobes are 0 and trap=1.
  - Opcode and mem_ready are ignored.
- Latency with mem_ready tied high: R-type 4 cycles, lw 5, sw 4, beq 3, j 3, addi 4. Each mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- Retired-instruction counter:
  - retired increments by 1 on the final-state exit edge: MEM_WB, MEM_WRITE with mem_ready=1, R_WB, BRANCH, JUMP, ADDI_WB.
  - It wraps modulo 2^CNT_W with no saturation.
  - A trapped instruction is not counted.
- mem_ready is sampled only in FETCH, MEM_READ and MEM_WRITE. It is ignored in all other states.
- Opcode is sampled only in DECODE and MEM_ADDR. IR is stable in both.
- Reset asserted mid-instruction, including during a wait state, forces FETCH immediately. The partial instruction is not counted. No write strobe may be seen after reset is asserted.
- No state outside the defined encodings is reachable. The default branch of the next-state logic goes to FETCH.

Decomposition:
- Shared package mips_mc_pkg holds:
  - the 4-bit state enum: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11, TRAP=15;
  - opcode constants;
  - ALUSrcB, ALUOp and PCSource encodings.
- One natural sub-module: mc_output_decode, a purely combinational state -> control-vector decode. The top module keeps the state register, next-state logic and counter.

Test Plan:
- R-type, mem_ready=1 -> states 0,1,6,7,0. RegWrite=1 and RegDst=1 only in cycle 4. retired goes 0 -> 1.
- lw with mem_ready low for 2 cycles in MEM_READ -> 7 cycles total. MemtoReg=1 and RegWrite=1 in the MEM_WB cycle. retired +1.
- sw then beq, mem_ready=1 -> sw takes 4 cycles with MemWrite=1, IorD=1 exactly once. beq takes 3 cycles with PCWriteCond=1, ALUOp=01. retired = 2.
- FETCH with mem_ready=0 for 3 cycles -> IRWrite=0 and PCWrite=0 throughout, then both 1 for exactly one cycle.
- Opcode 0x3F -> TRAP after DECODE. trap=1 and stays set. Strobes stay 0 for 10 cycles. retired is unchanged. Reset clears trap.
- Reset asserted in MEM_WRITE with mem_ready=0 -> state_o=0 and MemWrite=0 asynchronously. retired=0.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state encodings,
// opcodes, datapath select encodings and the control-vector layout.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC      = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11,
    TRAP      = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Purely combinational state -> control-vector decode. Only the FETCH
// IR/PC load strobes look at mem_ready; everything else is Moore.
module mc_output_decode
  import mips_mc_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEM_ADDR, ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      ADDI_WB: begin
        ctrl.reg_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencing controller: state register, next-state logic,
// retired-instruction counter and sticky undefined-opcode trap.
module multicycle_control
  import mips_mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [CNT_W-1:0] retired,
  output logic             trap,
  output logic [3:0]       state_o
);

  state_t state;
  state_t next_state;
  ctrl_t  ctrl;
  ctrl_t  ctrl_out;
  logic   retire_now;

  mc_output_decode u_decode (
    .state     (state),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  always_comb begin
    next_state = state;
    case (state)
      FETCH:     if (mem_ready) next_state = DECODE;
      DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: next_state = MEM_ADDR;
          OP_RTYPE:     next_state = EXEC;
          OP_BEQ:       next_state = BRANCH;
          OP_J:         next_state = JUMP;
          OP_ADDI:      next_state = ADDI_EXEC;
          default:      next_state = TRAP;
        endcase
      end
      MEM_ADDR:  next_state = (Opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ:  if (mem_ready) next_state = MEM_WB;
      MEM_WRITE: if (mem_ready) next_state = FETCH;
      EXEC:      next_state = R_WB;
      ADDI_EXEC: next_state = ADDI_WB;
      MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB: next_state = FETCH;
      TRAP:      next_state = TRAP;
      default:   next_state = FETCH;
    endcase
  end

  // An instruction retires on the edge that leaves its final state.
  always_comb begin
    case (state)
      MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB: retire_now = 1'b1;
      MEM_WRITE:                           retire_now = mem_ready;
      default:                             retire_now = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      retired <= '0;
      trap    <= 1'b0;
    end else begin
      state <= next_state;
      if (retire_now) retired <= retired + CNT_W'(1);
      if (next_state == TRAP) trap <= 1'b1;
    end
  end

  // Reset forces strobes low combinationally so no write escapes mid-cycle.
  assign ctrl_out    = reset ? '0 : ctrl;
  assign PCWrite     = ctrl_out.pc_write;
  assign PCWriteCond = ctrl_out.pc_write_cond;
  assign IorD        = ctrl_out.iord;
  assign MemRead     = ctrl_out.mem_read;
  assign MemWrite    = ctrl_out.mem_write;
  assign IRWrite     = ctrl_out.ir_write;
  assign MemtoReg    = ctrl_out.mem_to_reg;
  assign RegDst      = ctrl_out.reg_dst;
  assign RegWrite    = ctrl_out.reg_write;
  assign ALUSrcA     = ctrl_out.alu_src_a;
  assign ALUSrcB     = ctrl_out.alu_src_b;
  assign ALUOp       = ctrl_out.alu_op;
  assign PCSource    = ctrl_out.pc_source;
  assign state_o     = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: expected per-cycle state, controls,
// trap and retired count are queued as stimulus is driven, then popped and compared.
module tb_multicycle_control;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = 6'h00;
  logic        mem_ready = 1'b0;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [31:0] retired;
  logic        trap;
  logic [3:0]  state_o;

  multicycle_control #(.CNT_W(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .Opcode      (opcode),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .retired     (retired),
    .trap        (trap),
    .state_o     (state_o)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ctl;
    logic        trp;
    logic [31:0] ret;
  } obs_t;

  obs_t        sb[$];
  obs_t        exp_o;
  obs_t        got;
  int          checks = 0;
  int          fails = 0;
  logic [31:0] exp_ret = 32'd0;

  assign got = {state_o, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                trap, retired};

  // Expected control vector per state, written straight from the state table.
  function automatic logic [15:0] model_ctl(input logic [3:0] st, input logic mr);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, aop, ps;
    pcw = 0; pcwc = 0; iord = 0; mrd = 0; mwr = 0; irw = 0;
    m2r = 0; rdst = 0; rw = 0; srca = 0; srcb = 2'b00; aop = 2'b00; ps = 2'b00;
    case (st)
      4'd0:  begin mrd = 1; srcb = 2'b01; pcw = mr; irw = mr; end
      4'd1:  srcb = 2'b11;
      4'd2:  begin srca = 1; srcb = 2'b10; end
      4'd3:  begin mrd = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mwr = 1; iord = 1; end
      4'd6:  begin srca = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; rdst = 1; end
      4'd8:  begin srca = 1; aop = 2'b01; pcwc = 1; ps = 2'b01; end
      4'd9:  begin pcw = 1; ps = 2'b10; end
      4'd10: begin srca = 1; srcb = 2'b10; end
      4'd11: rw = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, ps};
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("st=%0d ctl=%h trap=%b ret=%0d", o.st, o.ctl, o.trp, o.ret);
  endfunction

  // Drives one cycle's inputs after the falling edge and queues what the DUT should show.
  task automatic expect_cycle(input logic [5:0] op, input logic mr,
                              input logic [3:0] st, input bit retires);
    obs_t e;
    @(negedge clock);
    opcode    = op;
    mem_ready = mr;
    e.st  = st;
    e.ctl = model_ctl(st, mr);
    e.trp = (st == 4'd15);
    e.ret = exp_ret;
    sb.push_back(e);
    if (retires) exp_ret = exp_ret + 32'd1;
    #1;
  endtask

  task automatic test_reset();
    #2;
    sb.push_back('{4'd0, 16'd0, 1'b0, 32'd0});
    exp_o = sb.pop_front();
    checks++;
    if (got !== exp_o) begin
      fails++;
      $display("[TB] FAIL reset_state: got %s, want %s", fmt(got), fmt(exp_o));
    end
    @(negedge clock);
    mem_ready = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_rtype();
    logic [3:0] sts [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
    for (int i = 0; i < 4; i++) begin
      expect_cycle(6'h00, 1'b1, sts[i], i == 3);
      exp_o = sb.pop_front();
      checks++;
      if (got !== exp_o) begin
        fails++;
        $display("[TB] FAIL rtype cyc %0d: got %s, want %s", i, fmt(got), fmt(exp_o));
      end
    end
  endtask

  task automatic test_lw_wait();
    logic [3:0] sts [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
    bit         mrs [7] = '{1, 1, 1, 0, 0, 1, 1};
    for (int i = 0; i < 7; i++) begin
      expect_cycle(6'h23, mrs[i], sts[i], i == 6);
      exp_o = sb.pop_front();
      checks++;
      if (got !== exp_o) begin
        fails++;
        $display("[TB] FAIL lw_wait cyc %0d: got %s, want %s", i, fmt(got), fmt(exp_o));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [14] = '{6'h2B, 6'h2B, 6'h2B, 6'h2B, 6'h04, 6'h04, 6'h04,
                             6'h02, 6'h02, 6'h02, 6'h08, 6'h08, 6'h08, 6'h08};
    logic [3:0] sts [14] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd1, 4'd8,
                             4'd0, 4'd1, 4'd9, 4'd0, 4'd1, 4'd10, 4'd11};
    bit         ret [14] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1};
    for (int i = 0; i < 14; i++) begin
      expect_cycle(ops[i], 1'b1, sts[i], ret[i]);
      exp_o = sb.pop_front();
      checks++;
      if (got !== exp_o) begin
        fails++;
        $display("[TB] FAIL back_to_back cyc %0d: got %s, want %s", i, fmt(got), fmt(exp_o));
      end
    end
  endtask

  task automatic test_fetch_wait();
    logic [3:0] sts [6] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd9};
    bit         mrs [6] = '{0, 0, 0, 1, 1, 1};
    for (int i = 0; i < 6; i++) begin
      expect_cycle(6'h02, mrs[i], sts[i], i == 5);
      exp_o = sb.pop_front();
      checks++;
      if (got !== exp_o) begin
        fails++;
        $display("[TB] FAIL fetch_wait cyc %0d: got %s, want %s", i, fmt(got), fmt(exp_o));
      end
    end
  endtask

  task automatic test_trap();
    logic [5:0] op;
    logic [3:0] st;
    logic       mr;
    for (int i = 0; i < 12; i++) begin
      op = (i < 2) ? 6'h3F : ((i % 2) != 0 ? 6'h23 : 6'h00);
      st = (i == 0) ? 4'd0 : ((i == 1) ? 4'd1 : 4'd15);
      mr = (i < 2) ? 1'b1 : 1'($urandom_range(0, 1));
      expect_cycle(op, mr, st, 1'b0);
      exp_o = sb.pop_front();
      checks++;
      if (got !== exp_o) begin
        fails++;
        $display("[TB] FAIL trap cyc %0d: got %s, want %s", i, fmt(got), fmt(exp_o));
      end
    end
    @(negedge clock);
    reset = 1'b1;
    exp_ret = 32'd0;
    #1;
    sb.push_back('{4'd0, 16'd0, 1'b0, 32'd0});
    exp_o = sb.pop_front();
    checks++;
    if (got !== exp_o) begin
      fails++;
      $display("[TB] FAIL trap_reset: got %s, want %s", fmt(got), fmt(exp_o));
    end
    mem_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    logic [3:0] sts [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
    bit         mrs [5] = '{1, 1, 1, 0, 0};
    for (int i = 0; i < 5; i++) begin
      expect_cycle(6'h2B, mrs[i], sts[i], 1'b0);
      exp_o = sb.pop_front();
      checks++;
      if (got !== exp_o) begin
        fails++;
        $display("[TB] FAIL mid_write cyc %0d: got %s, want %s", i, fmt(got), fmt(exp_o));
      end
    end
    // Assert reset between clock edges while MEM_WRITE is waiting.
    #2;
    reset = 1'b1;
    exp_ret = 32'd0;
    #1;
    sb.push_back('{4'd0, 16'd0, 1'b0, 32'd0});
    exp_o = sb.pop_front();
    checks++;
    if (got !== exp_o) begin
      fails++;
      $display("[TB] FAIL mid_write_async_reset: got %s, want %s", fmt(got), fmt(exp_o));
    end
    @(posedge clock);
    #1;
    sb.push_back('{4'd0, 16'd0, 1'b0, 32'd0});
    exp_o = sb.pop_front();
    checks++;
    if (got !== exp_o) begin
      fails++;
      $display("[TB] FAIL mid_write_reset_held: got %s, want %s", fmt(got), fmt(exp_o));
    end
    mem_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    expect_cycle(6'h00, 1'b0, 4'd0, 1'b0);
    exp_o = sb.pop_front();
    checks++;
    if (got !== exp_o) begin
      fails++;
      $display("[TB] FAIL mid_write_restart: got %s, want %s", fmt(got), fmt(exp_o));
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_back_to_back();
    test_fetch_wait();
    test_trap();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no end of test, want end within 100000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
